// File: rtl/rf_riscv_mp.sv
// rf_riscv_mp: parametrised multi-port integer register file with an optional
// write-to-read bypass and a per-register busy scoreboard for hazard checks.
// Reads are combinational; writes and scoreboard updates happen on the rising edge.
module rf_riscv_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = (NREGS > 2) ? $clog2(NREGS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NWR-1:0]       write_enable_i,
  input  logic [NWR*AW-1:0]    write_addr_i,
  input  logic [NWR*XLEN-1:0]  write_data_i,
  input  logic [NRD*AW-1:0]    read_addr_i,
  output logic [NRD*XLEN-1:0]  read_data_o,
  output logic [NRD-1:0]       read_busy_o,
  input  logic                 busy_set_i,
  input  logic [AW-1:0]        busy_set_addr_i,
  output logic [NREGS-1:0]     busy_o
);

  // Refuse to elaborate with parameters outside the supported ranges.
  if (XLEN < 1 || NREGS < 2 || NREGS > 64 || NRD < 1 || NRD > 4 ||
      NWR < 1 || NWR > 2 || (BYPASS != 0 && BYPASS != 1) ||
      (ZERO_REG != 0 && ZERO_REG != 1)) begin : g_param_check
    $error("rf_riscv_mp: parameter out of supported range");
  end

  // An address is usable when it names an existing register other than a
  // hardwired x0; everything else reads as zero and is never written.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    logic [31:0] ai;
    ai = 32'(a);
    addr_ok = (ai < 32'(NREGS)) && !((ZERO_REG != 0) && (ai == 32'd0));
  endfunction

  logic [XLEN-1:0]  regs_reg [NREGS];
  logic [NREGS-1:0] busy_reg;

  logic [NWR-1:0]   wr_ok;       // port k performs a real write this cycle
  logic             set_ok;      // busy-set address is usable
  logic [NREGS-1:0] wr_hit;      // register r is written this cycle
  logic [XLEN-1:0]  wr_val [NREGS];
  logic [NREGS-1:0] set_hit;     // register r is marked busy this cycle

  assign busy_o = busy_reg;
  assign set_ok = addr_ok(busy_set_addr_i);

  // Qualify each write port: enabled, not in reset, address in range.
  for (genvar gi = 0; gi < NWR; gi++) begin : g_wport
    assign wr_ok[gi] = write_enable_i[gi] && !rst_i &&
                       addr_ok(write_addr_i[gi*AW +: AW]);
  end

  // Per-register write decode; ascending port order lets the highest port win.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      wr_hit[r]  = 1'b0;
      wr_val[r]  = regs_reg[r];
      set_hit[r] = busy_set_i && set_ok && (busy_set_addr_i == AW'(r));
      for (int k = 0; k < NWR; k++) begin
        if (wr_ok[k] && (write_addr_i[k*AW +: AW] == AW'(r))) begin
          wr_hit[r] = 1'b1;
          wr_val[r] = write_data_i[k*XLEN +: XLEN];
        end
      end
    end
  end

  // Register and scoreboard state; a new producer's set beats a retiring write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_reg[r] <= '0;
      end
      busy_reg <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (wr_hit[r]) begin
          regs_reg[r] <= wr_val[r];
        end
        if (set_hit[r]) begin
          busy_reg[r] <= 1'b1;
        end else if (wr_hit[r]) begin
          busy_reg[r] <= 1'b0;
        end
      end
    end
  end

  // Read ports: stored value/busy, optionally overridden by a same-cycle write.
  for (genvar gi = 0; gi < NRD; gi++) begin : g_rport
    logic [AW-1:0]   ra;
    logic            rd_ok;
    logic [XLEN-1:0] stored_val;
    logic            stored_busy;
    logic            byp_hit;
    logic [XLEN-1:0] byp_val;
    logic            set_here;
    logic [XLEN-1:0] rdata;
    logic            rbusy;

    assign ra    = read_addr_i[gi*AW +: AW];
    assign rd_ok = addr_ok(ra);

    // Select stored state, find the highest matching write, and form outputs.
    always_comb begin
      stored_val  = '0;
      stored_busy = 1'b0;
      for (int r = 0; r < NREGS; r++) begin
        if (ra == AW'(r)) begin
          stored_val  = regs_reg[r];
          stored_busy = busy_reg[r];
        end
      end
      byp_hit = 1'b0;
      byp_val = '0;
      for (int k = 0; k < NWR; k++) begin
        if (wr_ok[k] && (write_addr_i[k*AW +: AW] == ra)) begin
          byp_hit = 1'b1;
          byp_val = write_data_i[k*XLEN +: XLEN];
        end
      end
      set_here = busy_set_i && set_ok && (busy_set_addr_i == ra);
      rdata = '0;
      rbusy = 1'b0;
      if (!rst_i && rd_ok) begin
        rdata = ((BYPASS != 0) && byp_hit) ? byp_val : stored_val;
        rbusy = stored_busy && !((BYPASS != 0) && byp_hit && !set_here);
      end
    end

    assign read_data_o[gi*XLEN +: XLEN] = rdata;
    assign read_busy_o[gi]              = rbusy;
  end

endmodule

// File: tb/tb_rf_riscv_mp.sv
// Testbench for rf_riscv_mp: three instances (bypass, no bypass, 24x64),
// directed stimulus pushes expectations into a scoreboard queue that a
// negedge monitor pops and compares against the DUT outputs.
module tb_rf_riscv_mp;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Shared inputs for the two 32x32 instances
  logic [1:0]  we;
  logic [9:0]  wa;
  logic [63:0] wd;
  logic [9:0]  ra;
  logic        bs;
  logic [4:0]  bsa;
  logic [63:0] rd0, rd1;
  logic [1:0]  rb0, rb1;
  logic [31:0] busy0, busy1;

  // 24 x 64 instance
  logic [1:0]   we2;
  logic [9:0]   wa2;
  logic [127:0] wd2;
  logic [9:0]   ra2;
  logic         bs2;
  logic [4:0]   bsa2;
  logic [127:0] rd2;
  logic [1:0]   rb2;
  logic [23:0]  busy2;

  rf_riscv_mp #(.BYPASS(1)) u0 (
    .clk_i(clk), .rst_i(rst), .write_enable_i(we), .write_addr_i(wa),
    .write_data_i(wd), .read_addr_i(ra), .read_data_o(rd0), .read_busy_o(rb0),
    .busy_set_i(bs), .busy_set_addr_i(bsa), .busy_o(busy0));

  rf_riscv_mp #(.BYPASS(0)) u1 (
    .clk_i(clk), .rst_i(rst), .write_enable_i(we), .write_addr_i(wa),
    .write_data_i(wd), .read_addr_i(ra), .read_data_o(rd1), .read_busy_o(rb1),
    .busy_set_i(bs), .busy_set_addr_i(bsa), .busy_o(busy1));

  rf_riscv_mp #(.XLEN(64), .NREGS(24)) u2 (
    .clk_i(clk), .rst_i(rst), .write_enable_i(we2), .write_addr_i(wa2),
    .write_data_i(wd2), .read_addr_i(ra2), .read_data_o(rd2), .read_busy_o(rb2),
    .busy_set_i(bs2), .busy_set_addr_i(bsa2), .busy_o(busy2));

  typedef struct {
    int          cyc;
    int          dut;
    int          kind;   // 0 read data, 1 read busy, 2 busy vector
    int          port;
    logic [63:0] val;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_err  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(int dut, int kind, int port, logic [63:0] v, string n);
    exp_t e;
    e.cyc = cyc; e.dut = dut; e.kind = kind; e.port = port; e.val = v; e.name = n;
    sbq.push_back(e);
  endfunction
  function automatic void exp_d(int dut, int port, logic [63:0] v, string n);
    push(dut, 0, port, v, n);
  endfunction
  function automatic void exp_b(int dut, int port, logic [63:0] v, string n);
    push(dut, 1, port, v, n);
  endfunction
  function automatic void exp_v(int dut, logic [63:0] v, string n);
    push(dut, 2, 0, v, n);
  endfunction

  function automatic logic [63:0] get_act(exp_t e);
    logic [63:0] a;
    a = '0;
    case (e.dut)
      0: case (e.kind)
           0: a = {32'b0, rd0[e.port*32 +: 32]};
           1: a = 64'(rb0[e.port]);
           default: a = 64'(busy0);
         endcase
      1: case (e.kind)
           0: a = {32'b0, rd1[e.port*32 +: 32]};
           1: a = 64'(rb1[e.port]);
           default: a = 64'(busy1);
         endcase
      default: case (e.kind)
           0: a = rd2[e.port*64 +: 64];
           1: a = 64'(rb2[e.port]);
           default: a = 64'(busy2);
         endcase
    endcase
    return a;
  endfunction

  // Monitor: compare every expectation due in the current cycle
  always @(negedge clk) begin
    exp_t        e;
    logic [63:0] act;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e   = sbq.pop_front();
      act = get_act(e);
      n_vec++;
      if (e.cyc != cyc || act !== e.val) begin
        n_err++;
        $display("FAIL %s (dut%0d port%0d cyc%0d): got %h expected %h",
                 e.name, e.dut, e.port, e.cyc, act, e.val);
      end else begin
        $display("ok   %s (dut%0d port%0d cyc%0d): %h", e.name, e.dut, e.port, e.cyc, act);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = '0; wa = '0; wd = '0; bs = 1'b0; bsa = '0;
    we2 = '0; wa2 = '0; wd2 = '0; bs2 = 1'b0; bsa2 = '0;
  endtask

  task automatic wr(input int k, input int a, input logic [31:0] d);
    we[k] = 1'b1; wa[k*5 +: 5] = 5'(a); wd[k*32 +: 32] = d;
  endtask
  task automatic rdp(input int p, input int a);
    ra[p*5 +: 5] = 5'(a);
  endtask
  task automatic wr2(input int k, input int a, input logic [63:0] d);
    we2[k] = 1'b1; wa2[k*5 +: 5] = 5'(a); wd2[k*64 +: 64] = d;
  endtask
  task automatic rdp2(input int p, input int a);
    ra2[p*5 +: 5] = 5'(a);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; idle(); ra = '0; ra2 = '0;
    tick();
    // Reset held: writes and busy sets ignored, outputs zero
    wr(0, 5, 32'h12345678); bs = 1'b1; bsa = 5'd5; rdp(0, 5); rdp(1, 5);
    exp_d(0, 0, 0, "rst_rd"); exp_d(1, 0, 0, "rst_rd_nb"); exp_b(0, 0, 0, "rst_rb");
    exp_v(0, 0, "rst_busy");
    tick();
    tick();
    rst = 1'b0; idle();
    // All registers zero after reset
    for (int a = 0; a < 32; a += 2) begin
      rdp(0, a); rdp(1, a + 1);
      exp_d(0, 0, 0, $sformatf("zero_x%0d", a));
      exp_d(0, 1, 0, $sformatf("zero_x%0d", a + 1));
      if (a == 0) begin
        exp_v(0, 0, "zero_busy");
        exp_v(2, 0, "zero_busy24");
      end
      tick();
    end
    // x0 is hardwired
    wr(0, 0, 32'hDEADBEEF); rdp(0, 0); exp_d(0, 0, 0, "x0_byp"); tick();
    idle(); exp_d(0, 0, 0, "x0_read"); exp_d(1, 0, 0, "x0_read_nb"); tick();
    // Dual write then read
    wr(0, 5, 32'h12345678); wr(1, 6, 32'hCAFEF00D); rdp(0, 5); rdp(1, 6);
    exp_d(0, 0, 32'h12345678, "byp_x5"); exp_d(0, 1, 32'hCAFEF00D, "byp_x6");
    exp_d(1, 0, 0, "nobyp_x5");
    tick();
    idle();
    exp_d(0, 0, 32'h12345678, "rd_x5"); exp_d(0, 1, 32'hCAFEF00D, "rd_x6");
    exp_d(1, 0, 32'h12345678, "rd_x5_nb"); exp_d(1, 1, 32'hCAFEF00D, "rd_x6_nb");
    tick();
    // Collision on x7: port 1 wins, bypass returns port 1 data
    wr(0, 7, 32'h777); tick();
    idle(); wr(0, 7, 32'h1111); wr(1, 7, 32'h2222); rdp(0, 7); rdp(1, 7);
    exp_d(0, 0, 32'h2222, "coll_byp"); exp_d(1, 0, 32'h777, "coll_old_nb");
    tick();
    idle(); exp_d(0, 0, 32'h2222, "coll_after"); exp_d(1, 1, 32'h2222, "coll_after_nb");
    tick();
    // Scoreboard on x9
    bs = 1'b1; bsa = 5'd9; rdp(0, 9); rdp(1, 9);
    exp_b(0, 0, 0, "sb_c1_rb"); exp_v(0, 0, "sb_c1_busy");
    tick();
    idle(); exp_v(0, 32'h200, "sb_c2_busy"); exp_b(0, 0, 1, "sb_c2_rb");
    exp_v(1, 32'h200, "sb_c2_busy_nb");
    tick();
    tick();
    wr(0, 9, 32'h99);
    exp_b(0, 0, 0, "sb_wr_byp_rb"); exp_b(1, 0, 1, "sb_wr_nobyp_rb");
    exp_d(0, 0, 32'h99, "sb_wr_byp_d"); exp_v(0, 32'h200, "sb_c4_busy");
    tick();
    idle(); exp_v(0, 0, "sb_clear"); exp_b(0, 0, 0, "sb_clear_rb"); exp_d(1, 0, 32'h99, "sb_x9_nb");
    bs = 1'b1; bsa = 5'd9; wr(1, 9, 32'hAB);
    tick();
    idle(); exp_v(0, 32'h200, "sb_setwin"); exp_v(1, 32'h200, "sb_setwin_nb");
    bs = 1'b1; bsa = 5'd9; wr(0, 9, 32'hCD);
    exp_b(0, 0, 1, "sb_setwr_rb"); exp_d(0, 0, 32'hCD, "sb_setwr_d");
    tick();
    idle(); exp_v(0, 32'h200, "sb_setwin2");
    bs = 1'b1; bsa = 5'd0; wr(0, 9, 32'hEF);
    exp_b(0, 0, 0, "sb_clr_rb");
    tick();
    idle(); exp_v(0, 0, "sb_x0_ignored"); exp_v(1, 0, "sb_x0_ignored_nb");
    tick();
    // Reset in the middle of operation
    wr(0, 3, 32'hA5A5A5A5); bs = 1'b1; bsa = 5'd3; tick();
    idle(); rdp(0, 3); rdp(1, 5);
    exp_d(0, 0, 32'hA5A5A5A5, "pre_rst_x3"); exp_v(0, 32'h8, "pre_rst_busy");
    tick();
    rst = 1'b1; wr(0, 3, 32'hFFFFFFFF);
    exp_d(0, 0, 0, "rst_mid_rd"); exp_b(0, 0, 0, "rst_mid_rb");
    tick();
    rst = 1'b0; idle();
    exp_d(0, 0, 0, "post_rst_x3"); exp_d(1, 0, 0, "post_rst_x3_nb");
    exp_d(0, 1, 0, "post_rst_x5"); exp_v(0, 0, "post_rst_busy"); exp_v(1, 0, "post_rst_busy_nb");
    tick();
    // 24-deep, 64-bit instance: invalid addresses and top register
    wr2(0, 30, 64'h5555555555555555); bs2 = 1'b1; bsa2 = 5'd30; rdp2(0, 30); rdp2(1, 14);
    exp_d(2, 0, 0, "d24_byp30"); exp_b(2, 0, 0, "d24_rb30");
    tick();
    idle();
    exp_d(2, 0, 0, "d24_rd30"); exp_d(2, 1, 0, "d24_rd14"); exp_v(2, 0, "d24_busy");
    wr2(1, 23, 64'h0123456789ABCDEF); bs2 = 1'b1; bsa2 = 5'd23;
    tick();
    idle(); rdp2(0, 23);
    exp_d(2, 0, 64'h0123456789ABCDEF, "d24_x23"); exp_v(2, 64'h800000, "d24_busy23");
    exp_b(2, 0, 1, "d24_rb23");
    tick();
    tick();
    n_vec++;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
